// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   mem_state_t   : data-memory handshake FSM states
//   stall_cause_t : winning hazard cause for a cycle
//   sat_inc       : saturating increment for the optional perf counters
// Optional feature macro: HAZARD_PERF_EN (perf counters in hazard_ctrl).
`ifndef REG_ADDR_WIDTH
`include "defines.sv"
`endif

package hazard_pkg;
  localparam int REG_AW = `REG_ADDR_WIDTH;
  localparam int PERF_W = 32;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    LU   = 3'd1,
    SB   = 3'd2,
    MW   = 3'd3,
    BR   = 3'd4
  } stall_cause_t;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/defines.sv
// Shared register-file address macros for the core.
//   REG_ADDR_WIDTH : width of an architectural register index
//   REG_ADDR_ZERO  : index of the hard-wired zero register
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_ADDR_ZERO
`define REG_ADDR_ZERO 5'd0
`endif

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for in-flight divider results.
//   clk, rst          : clock, synchronous active-high reset
//   set_en, set_addr  : mark a register as awaiting a divider result
//   clr_en, clr_addr  : divider writeback retires a register
//   pending           : registered per-register pending bits
//   busy              : registered, any pending bit set
// Clear is applied before set, so a same-address retire/issue leaves the
// bit set. Register 0 is never marked.
`ifndef REG_ADDR_WIDTH
`include "defines.sv"
`endif

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic                busy
);

  logic [NUM_REGS-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_addr] = 1'b0;
    if (set_en) pending_nxt[set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      busy    <= 1'b0;
    end else begin
      pending <= pending_nxt;
      busy    <= |pending_nxt;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush enables for IF/ID, ID/EX, EX/MEM
// covering load-use, pending divider writes (scoreboard), data-memory wait
// states and taken-branch redirects.
//   clk, rst                       : clock, synchronous active-high reset
//   rs1/rs2_rd_en_id, *_addr_id    : ID-stage source operands
//   rd_wr_en_id, rd_addr_id        : ID-stage destination
//   div_op_id                      : ID instruction is a divide
//   mem_read_ex, rd_addr_ex        : EX-stage load and its destination
//   div_issue_ex                   : EX launches a divide to rd_addr_ex
//   branch_taken_ex                : EX redirects the fetch stream
//   div_done, div_rd_addr          : divider writeback
//   dmem_req_mem, dmem_ready       : data-memory handshake
//   stall_*, flush_*               : pipeline control
//   div_busy                       : any divider result pending
//   mem_state_dbg                  : memory handshake FSM state
//   perf_*_cnt (HAZARD_PERF_EN)    : cycles each cause won, saturating
//
// Memory handshake: dmem_req_mem is the request valid, dmem_ready the
// completion. An access completes in the cycle both are high; once a wait
// has started the requester holds the request until ready, so in MEM_WAIT
// only dmem_ready is observed.
//
// Priority: memory wait > taken branch > load-use / scoreboard.
// Outputs are forced low during reset and the cycle after it.
`ifndef REG_ADDR_WIDTH
`include "defines.sv"
`endif

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rs1_rd_en_id,
  input  logic              rs2_rd_en_id,
  input  logic [REG_AW-1:0] rs1_addr_id,
  input  logic [REG_AW-1:0] rs2_addr_id,
  input  logic              rd_wr_en_id,
  input  logic [REG_AW-1:0] rd_addr_id,
  input  logic              div_op_id,
  input  logic              mem_read_ex,
  input  logic              div_issue_ex,
  input  logic [REG_AW-1:0] rd_addr_ex,
  input  logic              branch_taken_ex,
  input  logic              div_done,
  input  logic [REG_AW-1:0] div_rd_addr,
  input  logic              dmem_req_mem,
  input  logic              dmem_ready,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              div_busy,
  output mem_state_t        mem_state_dbg
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_lu_cnt,
  output logic [PERF_W-1:0] perf_sb_cnt,
  output logic [PERF_W-1:0] perf_mw_cnt
`endif
);

  logic [NUM_REGS-1:0] sb_pending;
  logic                sb_busy;
  logic                sb_set_en;
  logic                rst_q;
  logic                out_gate;
  logic                lu;
  logic                sb;
  logic                mw;
  mem_state_t          state_q;
  mem_state_t          state_d;
  stall_cause_t        cause;

  // Only non-zero destinations ever become pending.
  assign sb_set_en = div_issue_ex & (rd_addr_ex != `REG_ADDR_ZERO);

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set_en),
    .set_addr (rd_addr_ex),
    .clr_en   (div_done),
    .clr_addr (div_rd_addr),
    .pending  (sb_pending),
    .busy     (sb_busy)
  );

  // Extends the output blanking one cycle past reset deassertion.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  assign out_gate = rst | rst_q;

  // Hazard terms. The scoreboard is read from registers only, so the
  // writeback cycle still stalls and the write-first regfile serves the
  // operand on the following cycle.
  assign lu = mem_read_ex & (rd_addr_ex != `REG_ADDR_ZERO) &
              ((rs1_rd_en_id & (rs1_addr_id == rd_addr_ex)) |
               (rs2_rd_en_id & (rs2_addr_id == rd_addr_ex)));

  assign sb = (sb_pending[rs1_addr_id] & rs1_rd_en_id) |
              (sb_pending[rs2_addr_id] & rs2_rd_en_id) |
              (sb_pending[rd_addr_id]  & rd_wr_en_id)  |
              (div_op_id & sb_busy);

  // Memory handshake FSM.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mw      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dmem_req_mem && !dmem_ready) begin
          state_d = MEM_WAIT;
          mw      = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) state_d = IDLE;
        else            mw      = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_state_dbg = state_q;

  // Winning cause. A branch seen during a memory wait is held in the
  // stalled EX stage and wins once the wait drops.
  always_comb begin
    cause = NONE;
    if (!out_gate) begin
      if (mw)                   cause = MW;
      else if (branch_taken_ex) cause = BR;
      else if (lu)              cause = LU;
      else if (sb)              cause = SB;
    end
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    unique case (cause)
      MW: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end
      BR: begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end
      LU, SB: begin
        // Hold fetch and decode, send a bubble into EX.
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
      default: ;
    endcase
  end

  assign div_busy = sb_busy & ~out_gate;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_cnt <= '0;
      perf_sb_cnt <= '0;
      perf_mw_cnt <= '0;
    end else begin
      if (cause == LU) perf_lu_cnt <= sat_inc(perf_lu_cnt);
      if (cause == SB) perf_sb_cnt <= sat_inc(perf_sb_cnt);
      if (cause == MW) perf_mw_cnt <= sat_inc(perf_mw_cnt);
    end
  end
`endif

endmodule
